mem_arbiter: RTL

Arbiter that shares one external memory bus between the IF-stage instruction fetch and the MEM-stage load/store port of the 5-stage pipeline. Grants one transaction at a time, drives a request/acknowledge bus and returns captured read data to each requester. Raises per-stage stall requests toward `control` until each transaction completes, and bounds every bus transaction with a watchdog timeout.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter_bus_watchdog.sv | 29 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// Holds the arbiter state encoding and the bus constants used on grant and completion.
package arbiter_defines;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arbiter_state_t;

  localparam logic [3:0]  BUS_SELECT_WORD = 4'b1111;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// External memory bus: request/acknowledge handshake plus the sticky timeout flag.
// The arbiter drives the bus as master; the memory responds as slave.
interface mem_arbiter_if;

  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_select;
  logic [31:0] bus_write_data;
  logic        bus_ack;
  logic [31:0] bus_read_data;
  logic        bus_error;

  modport master (
    output bus_request, bus_write, bus_address, bus_select, bus_write_data, bus_error,
    input  bus_ack, bus_read_data
  );

  modport slave (
    input  bus_request, bus_write, bus_address, bus_select, bus_write_data, bus_error,
    output bus_ack, bus_read_data
  );

endinterface

// File: rtl/mem_arbiter_bus_watchdog.sv
// Cycle counter bounding one bus transaction; expired flags the last allowed cycle
// so the arbiter can complete the transaction on that edge.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  assign expired = enable && (count == LAST_COUNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between IF fetches and MEM loads/stores, data first,
// one transaction at a time, with a watchdog completing any unanswered request.
module mem_arbiter
  import arbiter_defines::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_request,
  input  logic [31:0] if_address,
  input  logic        if_hold,
  output logic [31:0] if_instruction,
  output logic        if_done,
  output logic        if_stall_request,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_write_select,
  input  logic [31:0] mem_write_data,
  input  logic        mem_hold,
  output logic [31:0] mem_read_data,
  output logic        mem_done,
  output logic        mem_stall_request,
  mem_arbiter_if.master bus
);

  arbiter_state_t state, next_state;
  logic           data_pending, fetch_pending;
  logic           grant_data, grant_inst, complete;
  logic           expired, timed_out;
  logic [31:0]    return_word;

  assign data_pending      = (mem_read_enable | mem_write_enable) & ~mem_done;
  assign fetch_pending     = if_request & ~if_done;
  assign if_stall_request  = if_request & ~if_done;
  assign mem_stall_request = (mem_read_enable | mem_write_enable) & ~mem_done;

  // An ack arriving in the expiry cycle still wins, so only a silent bus times out.
  assign timed_out   = expired & ~bus.bus_ack;
  assign return_word = bus.bus_ack ? bus.bus_read_data : ZERO_WORD;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (grant_data | grant_inst),
    .enable (state != IDLE),
    .expired(expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (data_pending) begin
          next_state = DATA;
          grant_data = 1'b1;
        end else if (fetch_pending) begin
          next_state = INST;
          grant_inst = 1'b1;
        end
      end
      DATA, INST: begin
        if (bus.bus_ack || expired) begin
          next_state = IDLE;
          complete   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Done flags persist until the pipeline register captures (hold low), then clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.bus_request    <= 1'b0;
      bus.bus_write      <= 1'b0;
      bus.bus_address    <= ZERO_WORD;
      bus.bus_select     <= 4'b0000;
      bus.bus_write_data <= ZERO_WORD;
      bus.bus_error      <= 1'b0;
      if_instruction     <= ZERO_WORD;
      if_done            <= 1'b0;
      mem_read_data      <= ZERO_WORD;
      mem_done           <= 1'b0;
    end else begin
      if (if_done && !if_hold) begin
        if_done <= 1'b0;
      end
      if (mem_done && !mem_hold) begin
        mem_done <= 1'b0;
      end
      if (grant_data) begin
        bus.bus_request    <= 1'b1;
        bus.bus_write      <= mem_write_enable;
        bus.bus_address    <= mem_address;
        bus.bus_select     <= mem_write_enable ? mem_write_select : BUS_SELECT_WORD;
        bus.bus_write_data <= mem_write_enable ? mem_write_data : ZERO_WORD;
      end else if (grant_inst) begin
        bus.bus_request    <= 1'b1;
        bus.bus_write      <= 1'b0;
        bus.bus_address    <= if_address;
        bus.bus_select     <= BUS_SELECT_WORD;
        bus.bus_write_data <= ZERO_WORD;
      end
      if (complete) begin
        bus.bus_request <= 1'b0;
        if (timed_out) begin
          bus.bus_error <= 1'b1;
        end
        if (state == DATA) begin
          mem_read_data <= bus.bus_write ? ZERO_WORD : return_word;
          mem_done      <= 1'b1;
        end else begin
          if_instruction <= return_word;
          if_done        <= 1'b1;
        end
      end
    end
  end

endmodule
